// File: rtl/ddr_tx_scheduler_if.sv
// ddr_tx_scheduler_if: requester handshakes and DDR lane outputs of the scheduler
interface ddr_tx_scheduler_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             d_rise;
  logic             d_fall;
  logic             frame_active;
  logic             grant_id;
  logic             frame_done;
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, d_rise, d_fall, frame_active, grant_id, frame_done
  );
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, d_rise, d_fall, frame_active, grant_id, frame_done
  );
endinterface

// File: rtl/ddr_tx_scheduler.sv
// ddr_tx_scheduler: round-robin share of one DDR lane, words sent MSB-first as bit pairs
module ddr_tx_scheduler #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input logic               clk,
  input logic               areset,
  ddr_tx_scheduler_if.slave bus
);
  localparam int KW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  state_t           state, nxt;
  logic [WIDTH-1:0] sr, word;
  logic [KW-1:0]    k;
  logic [3:0]       gcnt;
  logic             last_grant, win, hs, last;
  // state register
  always_ff @(posedge clk or posedge areset)
    if (areset) state <= S_IDLE;
    else state <= nxt;
  // arbitration, readies and next state
  always_comb begin
    win = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    hs = (state == S_IDLE) && (bus.req0_valid || bus.req1_valid);
    bus.req0_ready = (state == S_IDLE) && bus.req0_valid && !win;
    bus.req1_ready = (state == S_IDLE) && bus.req1_valid && win;
    word = win ? bus.req1_data : bus.req0_data;
    last = k == KW'(WIDTH/2 - 1);
    nxt = state;
    case (state)
      S_IDLE:  nxt = hs ? S_SHIFT : S_IDLE;
      S_SHIFT: nxt = last ? ((GAP > 0) ? S_GAP : S_IDLE) : S_SHIFT;
      default: nxt = (gcnt == 4'(GAP - 1)) ? S_IDLE : S_GAP;
    endcase
  end
  // the first pair is registered at the accepting edge so it shows one cycle later
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      sr <= '0;
      k <= '0;
      gcnt <= '0;
      bus.d_rise <= 1'b0;
      bus.d_fall <= 1'b0;
      bus.frame_active <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.grant_id <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (hs) begin
        sr <= word << 2;
        k <= '0;
        bus.d_rise <= word[WIDTH-1];
        bus.d_fall <= word[WIDTH-2];
        bus.frame_active <= 1'b1;
        bus.frame_done <= WIDTH == 2;
        bus.grant_id <= win;
        last_grant <= win;
      end else if (state == S_SHIFT && !last) begin
        sr <= sr << 2;
        k <= k + 1'b1;
        bus.d_rise <= sr[WIDTH-1];
        bus.d_fall <= sr[WIDTH-2];
        bus.frame_done <= (k + 1'b1) == KW'(WIDTH/2 - 1);
      end else begin
        bus.d_rise <= 1'b0;
        bus.d_fall <= 1'b0;
        bus.frame_active <= 1'b0;
        bus.frame_done <= 1'b0;
      end
      gcnt <= (state == S_GAP) ? gcnt + 1'b1 : 4'd0;
    end
endmodule

// File: tb/tb_ddr_tx_scheduler.sv
// tb_ddr_tx_scheduler: GAP=1 and GAP=0 schedulers driven alike, checked against a frame-timeline model
module tb_ddr_tx_scheduler;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r0v = 1'b0, r1v = 1'b0;
  logic [W-1:0] r0d = '0, r1d = '0;
  logic [1:0] rdy0, rdy1, dr, df, fa, fd, gd;
  int vectors = 0, miscompares = 0;
  int age[2];
  logic lg[2], gid[2];
  logic [W-1:0] w[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    ddr_tx_scheduler_if #(.WIDTH(W)) b();
    assign b.req0_valid = r0v;
    assign b.req0_data = r0d;
    assign b.req1_valid = r1v;
    assign b.req1_data = r1d;
    assign rdy0[g] = b.req0_ready;
    assign rdy1[g] = b.req1_ready;
    assign dr[g] = b.d_rise;
    assign df[g] = b.d_fall;
    assign fa[g] = b.frame_active;
    assign fd[g] = b.frame_done;
    assign gd[g] = b.grant_id;
    ddr_tx_scheduler #(.WIDTH(W), .GAP(g == 0 ? 1 : 0)) dut (.clk(clk), .areset(rst), .bus(b));
  end

  // age = cycles since the accepting edge; 0 means the scheduler is free to accept
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      age[i] = 0;
      lg[i] = 1'b1;
      gid[i] = 1'b0;
      w[i] = '0;
    end
  endtask

  function automatic logic winner(int i);
    return (r0v && r1v) ? !lg[i] : r1v;
  endfunction

  task automatic chk(input int e, input int inst);
    int n, k;
    logic f, idle, wn;
    logic [6:0] exp_v, got_v;
    logic [5:0] lit;
    for (int i = 0; i < 2; i++) begin
      n = age[i];
      f = n >= 1 && n <= W/2;
      k = f ? n - 1 : 0;
      idle = age[i] == 0;
      wn = winner(i);
      exp_v = {idle && r0v && !wn, idle && r1v && wn, f && w[i][W-1-2*k], f && w[i][W-2-2*k],
               f, f && (k == W/2 - 1), gid[i]};
      got_v = {rdy0[i], rdy1[i], dr[i], df[i], fa[i], fd[i], gd[i]};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL model_inst%0d t=%0t got=%b exp=%b (rdy0,rdy1,rise,fall,active,done,grant)",
                 i, $time, got_v, exp_v);
      end
    end
    if (e >= 0) begin
      lit = {rdy0[inst], rdy1[inst], dr[inst], df[inst], fa[inst], fd[inst]};
      vectors++;
      if (lit !== e[5:0]) begin
        miscompares++;
        $display("FAIL literal_inst%0d t=%0t got=%b exp=%b (rdy0,rdy1,rise,fall,active,done)",
                 inst, $time, lit, e[5:0]);
      end
    end
  endtask

  task automatic upd();
    logic wn;
    for (int i = 0; i < 2; i++) begin
      wn = winner(i);
      if (rst) begin
        age[i] = 0;
        lg[i] = 1'b1;
        gid[i] = 1'b0;
      end else if (age[i] == 0) begin
        if (r0v || r1v) begin
          w[i] = wn ? r1d : r0d;
          gid[i] = wn;
          lg[i] = wn;
          age[i] = 1;
        end
      end else begin
        age[i]++;
        if (age[i] > W/2 + (i == 0 ? 1 : 0)) age[i] = 0;
      end
    end
  endtask

  task automatic cyc(input int e = -1, input int inst = 0);
    @(negedge clk);
    chk(e, inst);
    @(posedge clk);
    upd();
    #1;
  endtask

  initial begin
    model_reset();
    cyc(0);
    cyc(0);
    rst = 1'b0;
    cyc(0);
    // single word B4
    r0v = 1'b1; r0d = 8'hB4;
    cyc(6'b100000);
    r0v = 1'b0;
    cyc(6'b001010); cyc(6'b001110); cyc(6'b000110); cyc(6'b000011);
    cyc(0); cyc(0);
    // async reset during k=2 of C3
    r0v = 1'b1; r0d = 8'hC3;
    cyc(6'b100000);
    r0v = 1'b0;
    cyc(6'b001110); cyc(6'b000010);
    #2;
    chk(6'b000010, 0);
    rst = 1'b1;
    model_reset();
    #1;
    chk(0, 0);
    cyc(0);
    rst = 1'b0;
    // contention: first grant to requester 0, then alternating
    r0v = 1'b1; r1v = 1'b1; r0d = 8'hFF; r1d = 8'h00;
    cyc(6'b100000);
    repeat (3) cyc(6'b001110);
    cyc(6'b001111); cyc(0);
    cyc(6'b010000);
    repeat (3) cyc(6'b000010);
    cyc(6'b000011); cyc(0);
    cyc(6'b100000);
    repeat (12) cyc();
    r0v = 1'b0; r1v = 1'b0;
    repeat (8) cyc();
    // requester 1 streaming alone
    r1v = 1'b1; r1d = 8'h5A;
    cyc(6'b010000); cyc(6'b000110); cyc(6'b000110); cyc(6'b001010); cyc(6'b001011);
    cyc(0); cyc(6'b010000);
    repeat (8) cyc();
    r1v = 1'b0;
    repeat (8) cyc();
    // back-to-back 81 then 7E, literals on the GAP=0 instance
    r0v = 1'b1; r0d = 8'h81;
    cyc(6'b100000, 1);
    r0d = 8'h7E;
    cyc(6'b001010, 1); cyc(6'b000010, 1); cyc(6'b000010, 1); cyc(6'b000111, 1);
    cyc(6'b100000, 1); cyc(6'b000110, 1);
    r0v = 1'b0;
    cyc(6'b001110, 1); cyc(6'b001110, 1); cyc(6'b001011, 1); cyc(0, 1);
    repeat (8) cyc();
    // req1 valid pulse during a req0 frame is ignored
    r0v = 1'b1; r0d = 8'h3C;
    cyc(6'b100000);
    r0v = 1'b0;
    cyc(6'b000010);
    r1v = 1'b1; r1d = 8'hA5;
    cyc(6'b001110);
    r1v = 1'b0;
    cyc(6'b001110); cyc(6'b000011); cyc(0); cyc(0); cyc(0);
    repeat (4) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
